// File: rtl/ssd1306_spi_ctrl.sv
// SSD1306 4-wire SPI front end: synchronises the raw SPI pins into clk, assembles bytes,
// runs the addressing/display command set and emits byte writes into the page-organised frame buffer.
module ssd1306_spi_ctrl #(
   parameter int COLS   = 128,
   parameter int PAGES  = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              greset,
   input  logic              wclk,
   input  logic              din,
   input  logic              cs,
   input  logic              dc,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [7:0]        fb_data,
   output logic              disp_on,
   output logic              invert,
   output logic [7:0]        contrast
);
   localparam int CW = $clog2(COLS);
   localparam int PW = $clog2(PAGES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARG1 = 2'd1;
   localparam logic [1:0] S_ARG2 = 2'd2;
   localparam logic [1:0] S_SKIP = 2'd3;

   localparam logic [1:0] M_HORIZ = 2'b00;
   localparam logic [1:0] M_VERT  = 2'b01;
   localparam logic [1:0] M_PAGE  = 2'b10;

   // Pin order {dc, cs, din, wclk}; wclk and cs reset high so reset never fakes an edge or a select.
   localparam logic [3:0] SYNC_RST = 4'b0101;

   logic [3:0]        sync1_q, sync1_d, sync2_q, sync2_d;
   logic              wclk_prev_q, wclk_prev_d;
   logic              sclk_rise;
   logic [2:0]        cnt_q, cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              byte_valid_q, byte_valid_d;
   logic [7:0]        rx_byte_q, rx_byte_d;
   logic              rx_dc_q, rx_dc_d;
   logic [1:0]        state_q, state_d;
   logic [7:0]        cmd_q, cmd_d;
   logic [CW-1:0]     arg_q, arg_d;
   logic [1:0]        mode_q, mode_d;
   logic [CW-1:0]     col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
   logic [PW-1:0]     page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [7:0]        fb_data_q, fb_data_d;
   logic              disp_on_q, disp_on_d, invert_q, invert_d;
   logic [7:0]        contrast_q, contrast_d;

   always_comb begin
      sync1_d     = {dc, cs, din, wclk};
      sync2_d     = sync1_q;
      wclk_prev_d = sync2_q[0];
   end

   assign sclk_rise = sync2_q[0] & ~wclk_prev_q;

   always_comb begin
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      rx_byte_d    = rx_byte_q;
      rx_dc_d      = rx_dc_q;
      if (sync2_q[2]) begin
         cnt_d = 3'd0;
      end else if (sclk_rise) begin
         shift_d = {shift_q[6:0], sync2_q[1]};
         cnt_d   = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            byte_valid_d = 1'b1;
            rx_byte_d    = shift_d;
            rx_dc_d      = sync2_q[3];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      arg_d        = arg_q;
      mode_d       = mode_q;
      col_d        = col_q;
      col_start_d  = col_start_q;
      col_end_d    = col_end_q;
      page_d       = page_q;
      page_start_d = page_start_q;
      page_end_d   = page_end_q;
      fb_we_d      = 1'b0;
      fb_addr_d    = fb_addr_q;
      fb_data_d    = fb_data_q;
      disp_on_d    = disp_on_q;
      invert_d     = invert_q;
      contrast_d   = contrast_q;
      if (byte_valid_q && rx_dc_q) begin
         fb_we_d   = 1'b1;
         fb_addr_d = ADDR_W'(page_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
         fb_data_d = rx_byte_q;
         // ">=" rather than "==" so a window with start > end wraps on every byte.
         case (mode_q)
            M_HORIZ: begin
               if (col_q >= col_end_q) begin
                  col_d  = col_start_q;
                  page_d = (page_q >= page_end_q) ? page_start_q : page_q + PW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
            M_VERT: begin
               if (page_q >= page_end_q) begin
                  page_d = page_start_q;
                  col_d  = (col_q >= col_end_q) ? col_start_q : col_q + CW'(1);
               end else begin
                  page_d = page_q + PW'(1);
               end
            end
            default: begin
               col_d = (col_q >= col_end_q) ? col_start_q : col_q + CW'(1);
            end
         endcase
      end else if (byte_valid_q) begin
         case (state_q)
            S_IDLE: begin
               casez (rx_byte_q)
                  8'hAE: disp_on_d = 1'b0;
                  8'hAF: disp_on_d = 1'b1;
                  8'hA6: invert_d  = 1'b0;
                  8'hA7: invert_d  = 1'b1;
                  8'b0000_????: col_d[3:0]    = rx_byte_q[3:0];
                  8'b0001_0???: col_d[CW-1:4] = rx_byte_q[CW-5:0];
                  8'b1011_0???: page_d        = rx_byte_q[PW-1:0];
                  8'h81, 8'h20, 8'h21, 8'h22: begin
                     state_d = S_ARG1;
                     cmd_d   = rx_byte_q;
                  end
                  8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: state_d = S_SKIP;
                  default: ;
               endcase
            end
            S_ARG1: begin
               state_d = S_IDLE;
               case (cmd_q)
                  8'h81: contrast_d = rx_byte_q;
                  8'h20: if (rx_byte_q[1:0] != 2'b11) mode_d = rx_byte_q[1:0];
                  default: begin
                     arg_d   = rx_byte_q[CW-1:0];
                     state_d = S_ARG2;
                  end
               endcase
            end
            S_ARG2: begin
               state_d = S_IDLE;
               if (cmd_q == 8'h21) begin
                  col_start_d = arg_q;
                  col_end_d   = rx_byte_q[CW-1:0];
                  col_d       = arg_q;
               end else begin
                  page_start_d = arg_q[PW-1:0];
                  page_end_d   = rx_byte_q[PW-1:0];
                  page_d       = arg_q[PW-1:0];
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (greset) begin
         sync1_q      <= SYNC_RST;
         sync2_q      <= SYNC_RST;
         wclk_prev_q  <= 1'b1;
         cnt_q        <= 3'd0;
         shift_q      <= 8'd0;
         byte_valid_q <= 1'b0;
         rx_byte_q    <= 8'd0;
         rx_dc_q      <= 1'b0;
         state_q      <= S_IDLE;
         cmd_q        <= 8'd0;
         arg_q        <= '0;
         mode_q       <= M_PAGE;
         col_q        <= '0;
         col_start_q  <= '0;
         col_end_q    <= CW'(COLS - 1);
         page_q       <= '0;
         page_start_q <= '0;
         page_end_q   <= PW'(PAGES - 1);
         fb_we_q      <= 1'b0;
         fb_addr_q    <= '0;
         fb_data_q    <= 8'd0;
         disp_on_q    <= 1'b0;
         invert_q     <= 1'b0;
         contrast_q   <= 8'h7F;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         wclk_prev_q  <= wclk_prev_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         rx_byte_q    <= rx_byte_d;
         rx_dc_q      <= rx_dc_d;
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         arg_q        <= arg_d;
         mode_q       <= mode_d;
         col_q        <= col_d;
         col_start_q  <= col_start_d;
         col_end_q    <= col_end_d;
         page_q       <= page_d;
         page_start_q <= page_start_d;
         page_end_q   <= page_end_d;
         fb_we_q      <= fb_we_d;
         fb_addr_q    <= fb_addr_d;
         fb_data_q    <= fb_data_d;
         disp_on_q    <= disp_on_d;
         invert_q     <= invert_d;
         contrast_q   <= contrast_d;
      end
   end

   assign fb_we    = fb_we_q;
   assign fb_addr  = fb_addr_q;
   assign fb_data  = fb_data_q;
   assign disp_on  = disp_on_q;
   assign invert   = invert_q;
   assign contrast = contrast_q;
endmodule

// File: doc/ssd1306_spi_ctrl.md
Name: ssd1306_spi_ctrl

Overview:
- Decodes the SSD1306 4-wire SPI stream (SCLK, SDIN, CS#, D/C#) in the 25 MHz pixel-clock domain.
- Executes the addressing and display commands and emits byte-wide writes into the 1 KiB frame buffer (8 pages x 128 columns) that the VGA scan-out reads.
- Replaces the raw bit-serial capture path.
- Display on/off, invert and contrast are exported for the scan-out.

Parameters:
- COLS, 128, columns per page.
- PAGES, 8, pages (8 pixel rows each).
- ADDR_W, 10, frame-buffer byte address width (log2(COLS*PAGES)).

Ports:
- clk  in  1  pixel clock, 25 MHz; sole clock.
- greset  in  1  synchronous, active-high reset.
- wclk  in  1  raw SPI SCLK, asynchronous.
- din  in  1  raw SPI SDIN, asynchronous.
- cs  in  1  raw chip select, active low, asynchronous.
- dc  in  1  raw D/C#: 1 = data, 0 = command; asynchronous.
- fb_we  out  1  one-cycle frame-buffer write strobe.
- fb_addr  out  ADDR_W  byte address = page*COLS + col.
- fb_data  out  8  byte to write; bit0 = top row of the page.
- disp_on  out  1  display enabled (0xAF/0xAE).
- invert  out  1  inverse video (0xA7/0xA6).
- contrast  out  8  contrast register (0x81 argument).

Behaviour:
- **Input synchronisation and timing**
  - wclk, din, cs and dc each pass through a 2-FF synchronizer.
  - SCLK rising edges are detected on the synchronised wclk.
  - SCLK must be <= clk/4.
- **Byte assembly**
  - While synced cs = 0, each rising edge shifts din in MSB first and increments a 3-bit count.
  - dc is sampled on the 8th edge and tags the byte.
- **Chip select**
  - Synced cs = 1 clears the bit count; a partial byte is discarded.
  - A pending multi-byte command state is retained.
- **Latency**
  - Raw wclk rising edge of bit 0 (8th bit) to fb_we high = exactly 4 clk.
  - fb_we is high for exactly 1 cycle.
  - fb_addr/fb_data are valid while fb_we is high.
- **Data byte (dc = 1)**
  - Write to the current (page, col), then auto-increment:
  - HORIZ: col++; at col_end, col <= col_start and page advances (page_end -> page_start).
  - VERT: page++; at page_end, page <= page_start and col advances (col_end -> col_start).
  - PAGE: col++; at col_end, col <= col_start; page unchanged.
  - Increment takes effect before the next byte can complete.
- **Command FSM**
  - States: IDLE, ARG1, ARG2, SKIP1.
  - IDLE single-byte commands:
    - 0xAE/0xAF set disp_on = 0/1.
    - 0xA6/0xA7 set invert = 0/1.
    - 0x00-0x0F set col[3:0].
    - 0x10-0x17 set col[6:4].
    - 0xB0-0xB7 set page.
  - IDLE commands taking arguments:
    - 0x81 and 0x20 go to ARG1; the next command byte is the argument, then return to IDLE.
    - 0x20 argument [1:0]: 00 = HORIZ, 01 = VERT, 10 = PAGE, 11 = ignored.
    - 0x21 and 0x22 go to ARG1 -> ARG2 -> IDLE (start, end).
    - 0x21 sets col_start/col_end (7 bits) and col <= start.
    - 0x22 sets page_start/page_end (3 bits) and page <= start.
  - Skipped commands:
    - 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB go to SKIP1; the argument is discarded.
  - All other command bytes are ignored; the state stays IDLE.
  - A data byte received while in ARG/SKIP is written normally and the FSM state is kept.
- **Argument width**
  - Out-of-range argument bits are masked to field width (col 7 bits, page 3 bits).
  - If start > end, wrap occurs on every byte (address stays at start).
- **Reset values**
  - fb_we = 0, fb_addr = 0, fb_data = 0, disp_on = 0, invert = 0, contrast = 0x7F.
  - Mode PAGE, col = 0, page = 0.
  - col_start = 0, col_end = 127, page_start = 0, page_end = 7.
  - FSM IDLE, bit count 0.
- **Reset during a transfer** discards everything; the stream resumes cleanly at the next byte boundary after cs toggles.

Test Plan:
- Reset, then data bytes 0xA5, 0x3C -> fb_we pulses at addr 0 (data 0xA5) and addr 1 (data 0x3C); each pulse 1 cycle, 4 clk after the 8th raw wclk edge.
- Cmds 0x20,0x00, 0x21,0x7E,0x7F, 0x22,0x06,0x07, then 5 data bytes -> addresses 894, 895, 1022, 1023, 894.
- Cmds 0x20,0x01 (defaults), then 9 data bytes -> addresses 0, 128, 256, …, 896, then 1.
- Cmds 0xB3, 0x05, 0x12 in PAGE mode, then data at col 127 pre-set via 0x0F,0x17 -> first write addr 3*128+37 = 421; next test writes 511 then wraps to 384.
- Cmds 0xAF, 0xA7, 0x81,0x20, 0x8D,0x14 -> disp_on = 1, invert = 1, contrast = 0x20; the 0x14 argument changes nothing; 0xAE -> disp_on = 0.
- Raise cs after 5 bits, then send a full 0xFF data byte -> single write of 0xFF, no write from the partial byte. Assert greset mid-byte -> all outputs return to reset values on the next cycle.
